imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe_pkg.sv | 26 ++
 rtl/imm_extend_pipe_decode.sv | 38 +++
 rtl/imm_extend_pipe.sv | 89 ++++++++
 tb/tb_imm_extend_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_extend_pipe_pkg.sv
// Shared ImmSel encodings and the legality rule used by both the
// stage-1 error counter and the stage-2 decoder.
package imm_extend_pipe_pkg;

    typedef enum logic [2:0] {
        IMM_I  = 3'd0,
        IMM_D  = 3'd1,
        IMM_B  = 3'd2,
        IMM_CB = 3'd3,
        IMM_IW = 3'd4
    } imm_sel_e;

    // hw is Inst[22:21]; a 32-bit result cannot hold an IW shifted by 32 or 48.
    function automatic logic imm_illegal(input logic [2:0] sel,
                                         input logic [1:0] hw,
                                         input int         data_w);
        logic ill;
        ill = 1'b0;
        if (sel > IMM_IW)
            ill = 1'b1;
        else if (sel == IMM_IW && data_w == 32 && hw[1])
            ill = 1'b1;
        return ill;
    endfunction

endpackage

// File: rtl/imm_extend_pipe_decode.sv
// Combinational LEGv8 immediate extractor feeding the stage-2 register.
module imm_decode
    import imm_extend_pipe_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int BR_SHIFT = 0
) (
    input  logic [25:0]       inst_i,
    input  logic [2:0]        sel_i,
    output logic [DATA_W-1:0] imm_o,
    output logic              err_o
);

    logic [63:0] ext;
    logic        unused_ext;

    // Build the full 64-bit value, then truncate to the configured width.
    always_comb begin
        ext   = '0;
        err_o = imm_illegal(sel_i, inst_i[22:21], DATA_W);
        case (sel_i)
            IMM_I:   ext = {52'b0, inst_i[21:10]};
            IMM_D:   ext = {{55{inst_i[20]}}, inst_i[20:12]};
            IMM_B:   ext = {{38{inst_i[25]}}, inst_i[25:0]};
            IMM_CB:  ext = {{45{inst_i[23]}}, inst_i[23:5]};
            IMM_IW:  ext = {48'b0, inst_i[20:5]} << {inst_i[22:21], 4'b0};
            default: ext = '0;
        endcase
        if (BR_SHIFT == 1 && (sel_i == IMM_B || sel_i == IMM_CB))
            ext = ext << 2;
        if (err_o)
            ext = '0;
    end

    assign imm_o      = ext[DATA_W-1:0];
    assign unused_ext = ^ext;

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready pipeline: stage 1 holds the raw instruction,
// stage 2 holds the decoded immediate; counts accepted illegal selects.
module imm_extend_pipe
    import imm_extend_pipe_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int BR_SHIFT = 0,
    parameter int ERRCNT_W = 16
) (
    input  logic                CLK,
    input  logic                resetl,
    input  logic [31:0]         Inst,
    input  logic [2:0]          ImmSel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DATA_W-1:0]   BusImm,
    output logic                imm_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ERRCNT_W-1:0] err_count
);

    logic                s1_vld_q;
    logic [25:0]         s1_inst_q;
    logic [2:0]          s1_sel_q;
    logic                s2_vld_q;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic                err_q, err_d;
    logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
    logic                s1_adv, in_xfer, in_illegal;
    logic                unused_opc;

    assign s1_adv     = !s2_vld_q || out_ready;
    assign in_ready   = !s1_vld_q || s1_adv;
    assign in_xfer    = in_valid && in_ready;
    assign in_illegal = imm_illegal(ImmSel, Inst[22:21], DATA_W);
    // Opcode bits never influence the immediate, so stage 1 keeps only [25:0].
    assign unused_opc = ^Inst[31:26];

    imm_decode #(
        .DATA_W   (DATA_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_dec (
        .inst_i (s1_inst_q),
        .sel_i  (s1_sel_q),
        .imm_o  (imm_d),
        .err_o  (err_d)
    );

    always_comb begin
        errcnt_d = errcnt_q;
        if (in_xfer && in_illegal && errcnt_q != '1)
            errcnt_d = errcnt_q + ERRCNT_W'(1);
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            s1_vld_q  <= 1'b0;
            s1_inst_q <= '0;
            s1_sel_q  <= '0;
            s2_vld_q  <= 1'b0;
            imm_q     <= '0;
            err_q     <= 1'b0;
            errcnt_q  <= '0;
        end else begin
            if (in_ready)
                s1_vld_q <= in_valid;
            if (in_xfer) begin
                s1_inst_q <= Inst[25:0];
                s1_sel_q  <= ImmSel;
            end
            // Stage 2 only reloads when it is free or being drained.
            if (s1_adv) begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    imm_q <= imm_d;
                    err_q <= err_d;
                end
            end
            errcnt_q <= errcnt_d;
        end
    end

    assign BusImm    = imm_q;
    assign imm_err   = err_q;
    assign out_valid = s2_vld_q;
    assign err_count = errcnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: three configurations share one stimulus stream and
// are checked against an arithmetic reference model and an in-flight queue.
module tb_imm_extend_pipe;

    logic        CLK;
    logic        resetl;
    logic [31:0] Inst;
    logic [2:0]  ImmSel;
    logic        in_valid;
    logic        out_ready;

    logic        a_ir, a_ov, a_err;
    logic [63:0] a_imm;
    logic [15:0] a_cnt;
    logic        b_ir, b_ov, b_err;
    logic [63:0] b_imm;
    logic [1:0]  b_cnt;
    logic        c_ir, c_ov, c_err;
    logic [31:0] c_imm;
    logic [15:0] c_cnt;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    imm_extend_pipe u_a (
        .CLK(CLK), .resetl(resetl), .Inst(Inst), .ImmSel(ImmSel),
        .in_valid(in_valid), .in_ready(a_ir), .BusImm(a_imm), .imm_err(a_err),
        .out_valid(a_ov), .out_ready(out_ready), .err_count(a_cnt)
    );

    imm_extend_pipe #(.DATA_W(64), .BR_SHIFT(1), .ERRCNT_W(2)) u_b (
        .CLK(CLK), .resetl(resetl), .Inst(Inst), .ImmSel(ImmSel),
        .in_valid(in_valid), .in_ready(b_ir), .BusImm(b_imm), .imm_err(b_err),
        .out_valid(b_ov), .out_ready(out_ready), .err_count(b_cnt)
    );

    imm_extend_pipe #(.DATA_W(32), .BR_SHIFT(0), .ERRCNT_W(16)) u_c (
        .CLK(CLK), .resetl(resetl), .Inst(Inst), .ImmSel(ImmSel),
        .in_valid(in_valid), .in_ready(c_ir), .BusImm(c_imm), .imm_err(c_err),
        .out_valid(c_ov), .out_ready(out_ready), .err_count(c_cnt)
    );

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  sel;
        int          stamp;
    } ent_t;

    ent_t q[$];
    int   t = 0;
    int   cnt_a = 0, cnt_b = 0, cnt_c = 0;
    int   n_cmp = 0, n_bad = 0;

    // Two's-complement interpretation of an n-bit field.
    function automatic longint sext(input longint f, input int n);
        return (f >= (longint'(1) << (n - 1))) ? f - (longint'(1) << n) : f;
    endfunction

    // Returns {err, value} for one configuration.
    function automatic logic [64:0] ref_imm(input logic [31:0] inst, input logic [2:0] sel,
                                            input int dw, input int brs);
        longint v;
        logic   err;
        int     hw;
        v   = 0;
        err = 1'b0;
        hw  = int'(inst[22:21]);
        case (sel)
            3'd0: v = longint'(inst[21:10]);
            3'd1: v = sext(longint'(inst[20:12]), 9);
            3'd2: v = sext(longint'(inst[25:0]), 26) * (brs != 0 ? 4 : 1);
            3'd3: v = sext(longint'(inst[23:5]), 19) * (brs != 0 ? 4 : 1);
            3'd4: begin
                if (dw == 32 && hw >= 2) err = 1'b1;
                else v = longint'(inst[20:5]) << (16 * hw);
            end
            default: err = 1'b1;
        endcase
        if (err) v = 0;
        if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return {err, 64'(v)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check everything observable, update the model.
    task automatic step(input logic v, input logic [31:0] inst, input logic [2:0] sel,
                        input logic ordy, output logic acc);
        logic        exp_rdy, exp_ov;
        logic [64:0] ra, rb, rc;
        in_valid  = v;
        Inst      = inst;
        ImmSel    = sel;
        out_ready = ordy;
        #1;
        exp_rdy = (q.size() < 2) || ordy;
        exp_ov  = 1'b0;
        if (q.size() > 0) exp_ov = (t - q[0].stamp) >= 2;
        chk("a.in_ready", 64'(a_ir), 64'(exp_rdy));
        chk("b.in_ready", 64'(b_ir), 64'(exp_rdy));
        chk("c.in_ready", 64'(c_ir), 64'(exp_rdy));
        chk("a.out_valid", 64'(a_ov), 64'(exp_ov));
        chk("b.out_valid", 64'(b_ov), 64'(exp_ov));
        chk("c.out_valid", 64'(c_ov), 64'(exp_ov));
        if (exp_ov) begin
            ra = ref_imm(q[0].inst, q[0].sel, 64, 0);
            rb = ref_imm(q[0].inst, q[0].sel, 64, 1);
            rc = ref_imm(q[0].inst, q[0].sel, 32, 0);
            chk("a.BusImm", a_imm, ra[63:0]);
            chk("a.imm_err", 64'(a_err), 64'(ra[64]));
            chk("b.BusImm", b_imm, rb[63:0]);
            chk("b.imm_err", 64'(b_err), 64'(rb[64]));
            chk("c.BusImm", {32'b0, c_imm}, rc[63:0]);
            chk("c.imm_err", 64'(c_err), 64'(rc[64]));
        end
        chk("a.err_count", 64'(a_cnt), 64'(cnt_a));
        chk("b.err_count", 64'(b_cnt), 64'(cnt_b));
        chk("c.err_count", 64'(c_cnt), 64'(cnt_c));
        acc = v && exp_rdy;
        if (exp_ov && ordy) void'(q.pop_front());
        if (acc) begin
            q.push_back('{inst, sel, t});
            ra = ref_imm(inst, sel, 64, 0);
            rc = ref_imm(inst, sel, 32, 0);
            if (ra[64] && cnt_a < 65535) cnt_a++;
            if (ra[64] && cnt_b < 3)     cnt_b++;
            if (rc[64] && cnt_c < 65535) cnt_c++;
        end
        t++;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    logic [31:0] dir_inst [10];
    logic [2:0]  dir_sel  [10];
    logic [31:0] bp_inst  [4];
    logic [2:0]  bp_sel   [4];
    logic [2:0]  ill_sel  [5];
    logic        acc;
    int          idx;

    initial begin
        resetl    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Inst      = '0;
        ImmSel    = '0;
        #1 resetl = 1'b0;
        #2;
        chk("reset.a.out_valid", 64'(a_ov), 64'd0);
        chk("reset.a.BusImm", a_imm, 64'd0);
        chk("reset.a.imm_err", 64'(a_err), 64'd0);
        chk("reset.a.err_count", 64'(a_cnt), 64'd0);
        chk("reset.b.BusImm", b_imm, 64'd0);
        chk("reset.c.BusImm", {32'b0, c_imm}, 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        resetl = 1'b1;

        // Directed formats, streamed back to back.
        dir_inst[0] = {6'b000101, 26'h1555555};               dir_sel[0] = 3'd2;
        dir_inst[1] = {6'b100101, 26'h2AAAAAA};               dir_sel[1] = 3'd2;
        dir_inst[2] = 32'h155 << 12;                          dir_sel[2] = 3'd1;
        dir_inst[3] = 32'h5AAAA << 5;                         dir_sel[3] = 3'd3;
        dir_inst[4] = (32'hBEEF << 5) | (32'd3 << 21);        dir_sel[4] = 3'd4;
        dir_inst[5] = (32'h1234 << 5) | (32'd1 << 21);        dir_sel[5] = 3'd4;
        dir_inst[6] = (32'h8001 << 5) | (32'd2 << 21);        dir_sel[6] = 3'd4;
        dir_inst[7] = 32'hFFC0_0C00;                          dir_sel[7] = 3'd0;
        dir_inst[8] = 32'hDEAD_BEEF;                          dir_sel[8] = 3'd6;
        dir_inst[9] = 32'h0080_0000;                          dir_sel[9] = 3'd3;
        for (int i = 0; i < 10; i++) step(1'b1, dir_inst[i], dir_sel[i], 1'b1, acc);
        for (int i = 0; i < 3; i++)  step(1'b0, 32'h0, 3'd0, 1'b1, acc);

        // Backpressure: four inputs held until accepted, consumer stalled 5 cycles.
        for (int i = 0; i < 4; i++) begin
            bp_inst[i] = $urandom;
            bp_sel[i]  = 3'($urandom_range(0, 4));
        end
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            step(idx < 4, bp_inst[idx % 4], bp_sel[idx % 4], c >= 5, acc);
            if (acc) idx++;
        end

        // Illegal selects drive the 2-bit counter into saturation.
        ill_sel[0] = 3'd5; ill_sel[1] = 3'd6; ill_sel[2] = 3'd7;
        ill_sel[3] = 3'd5; ill_sel[4] = 3'd6;
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, ill_sel[i], 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 3'd0, 1'b1, acc);

        // Random traffic with random stalls.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 2) != 0), acc);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 3'd0, 1'b1, acc);

        // Reset with two entries in flight must clear everything without a clock edge.
        step(1'b1, $urandom, 3'd7, 1'b0, acc);
        step(1'b1, {6'b100101, 26'h2AAAAAA}, 3'd2, 1'b0, acc);
        step(1'b0, 32'h0, 3'd0, 1'b0, acc);
        in_valid = 1'b0;
        resetl   = 1'b0;
        #1;
        chk("midrst.a.out_valid", 64'(a_ov), 64'd0);
        chk("midrst.a.BusImm", a_imm, 64'd0);
        chk("midrst.a.err_count", 64'(a_cnt), 64'd0);
        chk("midrst.b.out_valid", 64'(b_ov), 64'd0);
        chk("midrst.b.BusImm", b_imm, 64'd0);
        chk("midrst.b.err_count", 64'(b_cnt), 64'd0);
        chk("midrst.c.out_valid", 64'(c_ov), 64'd0);
        q.delete();
        cnt_a = 0;
        cnt_b = 0;
        cnt_c = 0;
        @(negedge CLK);
        resetl = 1'b1;

        // Cold start after reset: latency and content as from power-up.
        step(1'b1, {6'b100101, 26'h2AAAAAA}, 3'd2, 1'b1, acc);
        step(1'b1, 32'h5AAAA << 5, 3'd3, 1'b1, acc);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 3'd0, 1'b1, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
